// File: rtl/median_s_axis_window.sv
// AXI4-Stream input stage of the median filter: two line buffers plus a 3x3 sliding window,
// emitted with valid / start-of-frame strobes one cycle after each processed pixel.
module median_s_axis_window #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IMG_WIDTH  = 10,
    parameter int unsigned IMG_HEIGHT = 10
) (
    input  logic                    i_clk,
    input  logic                    i_aresetn,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tuser,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [9*DATA_WIDTH-1:0] o_window,
    output logic                    o_image_data_valid,
    output logic                    o_start_of_frame,
    output logic                    o_frame_error
);

    localparam int unsigned ColW    = $clog2(IMG_WIDTH);
    localparam logic [11:0] LastCol = 12'(IMG_WIDTH - 1);
    localparam logic [11:0] LastRow = 12'(IMG_HEIGHT - 1);

    typedef enum logic [0:0] {StIdle, StActive} state_t;

    state_t                state;
    logic [11:0]           col;
    logic [11:0]           row;
    logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] win [9];

    logic            process;
    logic [11:0]     cur_col;
    logic [11:0]     cur_row;
    logic [ColW-1:0] idx;
    logic            last_col;
    logic            last_row;
    logic            tlast_bad;
    logic            frame_err;

    always_comb begin
        process   = s_axis_tvalid && s_axis_tready && (state == StActive || s_axis_tuser);
        // A tuser beat is always pixel (0,0), whatever the counters say.
        cur_col   = s_axis_tuser ? 12'd0 : col;
        cur_row   = s_axis_tuser ? 12'd0 : row;
        idx       = cur_col[ColW-1:0];
        last_col  = (cur_col == LastCol);
        last_row  = (cur_row == LastRow);
        tlast_bad = (s_axis_tlast != last_col);
        frame_err = process && (state == StActive) && (s_axis_tuser || tlast_bad);
    end

    always_comb begin
        o_window = '0;
        for (int k = 0; k < 9; k++) begin
            o_window[DATA_WIDTH*k +: DATA_WIDTH] = win[k];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_aresetn) begin
            state              <= StIdle;
            col                <= '0;
            row                <= '0;
            s_axis_tready      <= 1'b0;
            o_image_data_valid <= 1'b0;
            o_start_of_frame   <= 1'b0;
            o_frame_error      <= 1'b0;
            for (int i = 0; i < int'(IMG_WIDTH); i++) begin
                lb0[i] <= '0;
                lb1[i] <= '0;
            end
            for (int k = 0; k < 9; k++) begin
                win[k] <= '0;
            end
        end else begin
            s_axis_tready      <= 1'b1;
            o_image_data_valid <= process;
            o_start_of_frame   <= process && s_axis_tuser;
            o_frame_error      <= frame_err;
            if (process) begin
                lb1[idx] <= lb0[idx];
                lb0[idx] <= s_axis_tdata;
                // Shift left; new right column reads the pre-write buffer contents.
                win[0] <= win[1];
                win[1] <= win[2];
                win[2] <= lb1[idx];
                win[3] <= win[4];
                win[4] <= win[5];
                win[5] <= lb0[idx];
                win[6] <= win[7];
                win[7] <= win[8];
                win[8] <= s_axis_tdata;
                if (state == StActive && !s_axis_tuser && tlast_bad) begin
                    state <= StIdle;
                    col   <= '0;
                    row   <= '0;
                end else if (last_col) begin
                    col <= '0;
                    if (last_row) begin
                        row   <= '0;
                        state <= StIdle;
                    end else begin
                        row   <= cur_row + 12'd1;
                        state <= StActive;
                    end
                end else begin
                    col   <= cur_col + 12'd1;
                    row   <= cur_row;
                    state <= StActive;
                end
            end
        end
    end

endmodule
